// File: rtl/mem_access_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the memory access arbiter.
//   port_tag_t      - identifies which requester owns an in-flight read
//   WORD_BYTES      - bytes per memory word (one write-mask bit each)
//   MAX_MEM_LATENCY - largest supported memory read latency
//   read_tag()      - tag to push into the response tracker for a grant
package mem_arb_pkg;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_I    = 2'd1,
    PORT_D    = 2'd2
  } port_tag_t;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_MEM_LATENCY = 4;

  // Stores and idle cycles push PORT_NONE so they never produce a response.
  function automatic port_tag_t read_tag(input logic gnt_i, input logic gnt_d,
                                         input logic [WORD_BYTES-1:0] wmask);
    port_tag_t t;
    t = PORT_NONE;
    if (gnt_d) t = (wmask == '0) ? PORT_D : PORT_NONE;
    else if (gnt_i) t = PORT_I;
    return t;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: bundles the fetch (I) port, the load/store (D) port
// and the memory group bus.
//   slave  - arbiter view: takes requests and mem_read_data, drives readies,
//            responses and the memory address/mask/data.
//   master - environment view (requesters plus memory group).
interface mem_access_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 14
);
  // fetch port
  logic                    i_req_valid;
  logic                    i_req_ready;
  logic [ADDR_W-1:0]       i_req_addr;
  logic                    i_rsp_valid;
  logic [31:0]             i_rsp_data;
  // load/store port
  logic                    d_req_valid;
  logic                    d_req_ready;
  logic [ADDR_W-1:0]       d_req_addr;
  logic [WORD_BYTES-1:0]   d_req_write_mask;
  logic [31:0]             d_req_write_data;
  logic                    d_rsp_valid;
  logic [31:0]             d_rsp_data;
  // memory group
  logic [WORD_BYTES-1:0]   mem_write_mask;
  logic [ADDR_W-1:0]       mem_addr;
  logic [31:0]             mem_write_data;
  logic [31:0]             mem_read_data;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_valid, d_req_addr, d_req_write_mask, d_req_write_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_write_mask, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_valid, d_req_addr, d_req_write_mask, d_req_write_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_write_mask, mem_addr, mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/mem_access_arbiter_rsp_tracker.sv
// mem_arb_rsp_tracker: MEM_LATENCY-deep shift register of port tags.
// The tag pushed in the grant cycle reaches tag_o exactly MEM_LATENCY cycles
// later, lining up with mem_read_data for that read.
//   clk, rst  - clock, synchronous active-high reset (flushes to PORT_NONE)
//   tag_i     - tag of this cycle's grant
//   tag_o     - tag owning the current mem_read_data
module mem_arb_rsp_tracker
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  port_tag_t tag_i,
  output port_tag_t tag_o
);
  port_tag_t tags_q [MEM_LATENCY];
  port_tag_t tags_d [MEM_LATENCY];

  always_comb begin
    tags_d[0] = tag_i;
    for (int k = 1; k < MEM_LATENCY; k++) tags_d[k] = tags_q[k-1];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < MEM_LATENCY; k++) begin
      if (rst) tags_q[k] <= PORT_NONE;
      else     tags_q[k] <= tags_d[k];
    end
  end

  assign tag_o = tags_q[MEM_LATENCY-1];

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the single-port 4-bank memory group between the
// instruction fetch port (I, read-only) and the load/store port (D).
// One grant per cycle; read responses are routed back by a tag tracker.
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_access_arbiter_if.slave (I/D request+response, memory bus)
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate I/D on contention using a
// last-winner bit; otherwise D always beats I.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_DEPTH  = 4096,
  parameter int ADDR_W      = 2 + $clog2(DATA_DEPTH),
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_arbiter_if.slave  bus
);
  logic                  rst_dly_q;
  logic                  blk;
  logic                  contend;
  logic                  d_first;
  logic                  grant_i, grant_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [WORD_BYTES-1:0] wmask;
  logic [31:0]           wdata;
  port_tag_t             tag_in, tag_out;

  // Readies stay low during reset and the first cycle after it.
  always_ff @(posedge clk) rst_dly_q <= rst;
  assign blk     = rst | rst_dly_q;
  assign contend = bus.i_req_valid & bus.d_req_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_i_q: 1 = I won the last contended grant, so D goes next.
  logic last_i_q, last_i_d;
  assign d_first = last_i_q;

  always_comb begin
    last_i_d = last_i_q;
    if (contend && !blk) last_i_d = grant_i;
  end

  always_ff @(posedge clk) begin
    if (rst) last_i_q <= 1'b1;
    else     last_i_q <= last_i_d;
  end
`else
  assign d_first = 1'b1;
`endif

  assign grant_d = ~blk & bus.d_req_valid & (~bus.i_req_valid | d_first);
  assign grant_i = ~blk & bus.i_req_valid & ~grant_d;

  assign bus.d_req_ready = grant_d;
  assign bus.i_req_ready = grant_i;

  // Memory drive; address holds its last granted value when idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    wmask      = '0;
    wdata      = '0;
    if (grant_d) begin
      mem_addr_d = bus.d_req_addr;
      wmask      = bus.d_req_write_mask;
      wdata      = bus.d_req_write_data;
    end else if (grant_i) begin
      mem_addr_d = bus.i_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_addr_q <= '0;
    else     mem_addr_q <= mem_addr_d;
  end

  assign bus.mem_addr       = rst ? '0 : mem_addr_d;
  assign bus.mem_write_mask = wmask;
  assign bus.mem_write_data = wdata;

  assign tag_in = read_tag(grant_i, grant_d, bus.d_req_write_mask);

  mem_arb_rsp_tracker #(.MEM_LATENCY(MEM_LATENCY)) u_trk (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Tail may still hold a stale tag in the reset cycle itself; mask it.
  always_comb begin
    bus.i_rsp_valid = 1'b0;
    bus.i_rsp_data  = '0;
    bus.d_rsp_valid = 1'b0;
    bus.d_rsp_data  = '0;
    if (!rst) begin
      if (tag_out == PORT_I) begin
        bus.i_rsp_valid = 1'b1;
        bus.i_rsp_data  = bus.mem_read_data;
      end
      if (tag_out == PORT_D) begin
        bus.d_rsp_valid = 1'b1;
        bus.d_rsp_data  = bus.mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a reference model
// built from grant priority, a byte-array shadow memory and response due times.
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  localparam int DEPTH = 4096;
  localparam int AW    = 2 + $clog2(DEPTH);
  localparam int LAT   = 2;
  localparam int NB    = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.ADDR_W(AW)) bus();

  mem_access_arbiter #(.DATA_DEPTH(DEPTH), .ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 7 + 3);
  endfunction

  // Memory group stand-in: byte array, word = bytes addr..addr+3, fixed latency.
  logic [7:0]  mem_b   [NB];
  logic [31:0] rd_pipe [LAT];
  bit          filled = 1'b0;

  always @(posedge clk) begin
    if (!filled) begin
      for (int a = 0; a < NB; a++) mem_b[a] <= init_byte(a);
      filled <= 1'b1;
    end
    for (int k = 0; k < 4; k++)
      if (bus.mem_write_mask[k]) mem_b[AW'(bus.mem_addr + k)] <= bus.mem_write_data[8*k +: 8];
    rd_pipe[0] <= {mem_b[AW'(bus.mem_addr + 3)], mem_b[AW'(bus.mem_addr + 2)],
                   mem_b[AW'(bus.mem_addr + 1)], mem_b[AW'(bus.mem_addr)]};
    for (int k = LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus.mem_read_data = rd_pipe[LAT-1];

  // Reference model state
  logic [7:0]  shadow [NB];
  logic [31:0] exp_i [int];
  logic [31:0] exp_d [int];
  int          cyc = 0;
  bit          rst_prev = 1'b0;
  int          n_contend = 0;
  logic [AW-1:0] last_addr = '0;
  int          n_pass = 0;
  int          n_chk  = 0;
  bit          obs_i_rsp, obs_d_rdy;

  function automatic logic [31:0] shadow_word(input logic [AW-1:0] a);
    return {shadow[AW'(a + 3)], shadow[AW'(a + 2)], shadow[AW'(a + 1)], shadow[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic step(input bit r, input bit iv, input logic [AW-1:0] ia,
                      input bit dv, input logic [AW-1:0] da,
                      input logic [3:0] dm, input logic [31:0] dd);
    bit gi, gd, ei, ed;
    logic [AW-1:0] ea;
    @(negedge clk);
    rst                  = r;
    bus.i_req_valid      = iv;
    bus.i_req_addr       = ia;
    bus.d_req_valid      = dv;
    bus.d_req_addr       = da;
    bus.d_req_write_mask = dm;
    bus.d_req_write_data = dd;
    #1;
    gi = 1'b0;
    gd = 1'b0;
    if (!(r || rst_prev)) begin
      if (iv && dv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gd = (n_contend % 2) == 0;
        gi = !gd;
`else
        gd = 1'b1;
`endif
        n_contend++;
      end else begin
        gd = dv;
        gi = iv;
      end
    end
    if (r) begin
      exp_i.delete();
      exp_d.delete();
    end
    ea = r ? '0 : gd ? da : gi ? ia : last_addr;
    chk("i_req_ready", 32'(bus.i_req_ready), 32'(gi));
    chk("d_req_ready", 32'(bus.d_req_ready), 32'(gd));
    chk("mem_write_mask", 32'(bus.mem_write_mask), gd ? 32'(dm) : 32'd0);
    chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
    chk("mem_write_data", bus.mem_write_data, gd ? dd : 32'd0);
    ei = exp_i.exists(cyc);
    ed = exp_d.exists(cyc);
    chk("i_rsp_valid", 32'(bus.i_rsp_valid), 32'(ei));
    chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(ed));
    if (ei) begin chk("i_rsp_data", bus.i_rsp_data, exp_i[cyc]); exp_i.delete(cyc); end
    if (ed) begin chk("d_rsp_data", bus.d_rsp_data, exp_d[cyc]); exp_d.delete(cyc); end
    obs_i_rsp = bus.i_rsp_valid;
    obs_d_rdy = bus.d_req_ready;
    // model update for this cycle's grant
    if (gi) exp_i[cyc + LAT] = shadow_word(ia);
    if (gd && dm == 4'd0) exp_d[cyc + LAT] = shadow_word(da);
    if (gd) for (int k = 0; k < 4; k++) if (dm[k]) shadow[AW'(da + k)] = dd[8*k +: 8];
    last_addr = ea;
    if (r) n_contend = 0;
    rst_prev = r;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0, 4'd0, 32'd0);
  endtask

  initial begin
    int cnt;
    bit ip, dp, r;
    logic [AW-1:0] ia, da;
    logic [3:0] dm;
    logic [31:0] dd;
    for (int a = 0; a < NB; a++) shadow[a] = init_byte(a);
    rst = 1'b1;
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_addr = '0;
    bus.d_req_write_mask = '0; bus.d_req_write_data = '0;

    // reset with requests pending: no readies during reset or the cycle after
    step(1, 1, '0, 1, 14'h100, 4'd0, 32'd0);
    step(1, 1, '0, 0, '0, 4'd0, 32'd0);
    step(0, 1, '0, 0, '0, 4'd0, 32'd0);

    // I-only back-to-back reads
    cnt = 0;
    step(0, 1, 14'h000, 0, '0, 4'd0, 32'd0);
    step(0, 1, 14'h004, 0, '0, 4'd0, 32'd0);
    step(0, 1, 14'h008, 0, '0, 4'd0, 32'd0); cnt += int'(obs_i_rsp);
    for (int k = 0; k < 3; k++) begin idle(1); cnt += int'(obs_i_rsp); end
    chk("i_rsp_count", 32'(cnt), 32'd3);

    // contention: D store wins, I read next cycle
    step(0, 1, 14'h020, 1, 14'h010, 4'b1111, 32'hDEADBEEF);
    step(0, 1, 14'h020, 0, '0, 4'd0, 32'd0);
    idle(3);

    // partial store then overlapping load
    step(0, 0, '0, 1, 14'h011, 4'b0011, 32'h0000BEEF);
    step(0, 0, '0, 1, 14'h010, 4'b0000, 32'd0);
    idle(2);
    chk("partial_store_bytes", 32'(bus.d_rsp_data[23:8]), 32'h0000BEEF);
    idle(1);

    // sustained contention from a fresh reset
    step(1, 0, '0, 0, '0, 4'd0, 32'd0);
    idle(1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 14'h030, 1, AW'(14'h040 + 4 * k), 4'd0, 32'd0);
      cnt += int'(obs_d_rdy);
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("d_grant_count", 32'(cnt), 32'd3);
`else
    chk("d_grant_count", 32'(cnt), 32'd6);
`endif
    idle(3);

    // reset right after an I read drops its response
    step(0, 1, 14'h044, 0, '0, 4'd0, 32'd0);
    step(1, 0, '0, 0, '0, 4'd0, 32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin idle(1); cnt += int'(obs_i_rsp); end
    chk("i_rsp_after_rst", 32'(cnt), 32'd0);

    // address hold while idle
    step(0, 0, '0, 1, 14'h07C, 4'd0, 32'd0);
    idle(5);

    // randomized traffic with hold-until-accepted requesters
    ip = 0; dp = 0; ia = '0; da = '0; dm = '0; dd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = AW'($urandom_range(0, 63)); end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1;
        da = AW'($urandom_range(0, 63));
        dm = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
        dd = $urandom;
      end
      r = ($urandom_range(0, 99) == 0);
      step(r, ip, ia, dp, da, dm, dd);
      if (bus.i_req_ready) ip = 0;
      if (obs_d_rdy) dp = 0;
    end
    idle(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
